// File: rtl/unary_stream_gen.sv
// Unary (thermometer) stream pair generator feeding hv_generator.
// One (a, b) beat per hypervector dimension, b drawn from a reseeded LFSR.
module unary_stream_gen #(
  parameter int          DIM  = 1024,
  parameter logic [15:0] SEED = 16'hACE1,
  localparam int         IW   = $clog2(DIM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [4:0]    level,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [15:0]   a,
  output logic [15:0]   b,
  output logic [IW-1:0] idx,
  output logic          busy,
  output logic          done
);

  localparam logic [0:0]  S_IDLE = 1'b0;
  localparam logic [0:0]  S_RUN  = 1'b1;
  localparam logic [15:0] SEED_L = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] TAPS   = 16'hB400;

  logic [0:0]    state_q, state_d;
  logic [4:0]    lvl_q, lvl_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0]   a_q, a_d;
  logic [15:0]   b_q, b_d;
  logic          done_q, done_d;

  logic [4:0]  lvl_sat;
  logic [15:0] lfsr_nxt;
  logic        accept;
  logic        last;

  function automatic logic [15:0] therm(input logic [4:0] n);
    logic [16:0] t;
    t = (17'd1 << n) - 17'd1;
    return t[15:0];
  endfunction

  assign lvl_sat  = (level > 5'd16) ? 5'd16 : level;
  assign lfsr_nxt = {1'b0, lfsr_q[15:1]}
                  ^ (lfsr_q[0] ? TAPS : 16'h0000);
  assign accept   = (state_q == S_RUN) && out_ready;
  assign last     = (idx_q == IW'(DIM - 1));

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          lvl_d   = lvl_sat;
          lfsr_d  = SEED_L;
          idx_d   = '0;
          a_d     = therm(lvl_sat);
          b_d     = therm({1'b0, SEED_L[3:0]});
        end
      end
      S_RUN: begin
        if (accept) begin
          if (last) begin
            state_d = S_IDLE;
            idx_d   = '0;
            a_d     = '0;
            b_d     = '0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            lfsr_d = lfsr_nxt;
            b_d    = therm({1'b0, lfsr_nxt[3:0]});
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lvl_q   <= '0;
      lfsr_q  <= SEED_L;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = (state_q == S_RUN);
  assign busy      = (state_q == S_RUN);
  assign a         = a_q;
  assign b         = b_q;
  assign idx       = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_unary_stream_gen.sv
// Directed bench for unary_stream_gen with DIM=8, SEED=16'hACE1.
// Beats, stalls, back-to-back runs, level limits and mid-run reset.
module tb_unary_stream_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  level;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  idx;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  unary_stream_gen #(
    .DIM (8),
    .SEED(16'hACE1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .level    (level),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .a        (a),
    .b        (b),
    .idx      (idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] therm4(input logic [3:0] r);
    logic [15:0] t;
    t = '0;
    for (int i = 0; i < 16; i++)
      if (i < int'(r)) t[i] = 1'b1;
    return t;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_a"}, a, 0);
    check({tag, "_b"}, b, 0);
    check({tag, "_idx"}, idx, 0);
  endtask

  // Called at #1 after an edge; start is taken at the next edge.
  // Returns in the done cycle (one settle point after final accept).
  task automatic run(input logic [4:0]  lvl,
                     input logic [15:0] exp_a,
                     input bit          stall,
                     input bit          mid_start);
    logic [15:0] m;
    logic [15:0] hand_b [3];
    int beats;
    int c;
    hand_b[0] = 16'h0001;
    hand_b[1] = 16'h0000;
    hand_b[2] = 16'h00FF;
    m = 16'hACE1;
    beats = 0;
    start = 1'b1;
    level = lvl;
    step();
    start = 1'b0;
    level = 5'd0;
    c = 1;
    while (beats < 8 && c < 40) begin
      out_ready = !stall || ((c - 1) % 3 == 0);
      if (mid_start && c == 3) start = 1'b1;
      else start = 1'b0;
      check("run_valid", out_valid, 1);
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("beat_a", a, exp_a);
      check("beat_b", b, therm4(m[3:0]));
      check("beat_b15", b[15], 0);
      check("beat_idx", idx, beats);
      if (beats < 3) check("beat_b_hand", b, hand_b[beats]);
      if (out_ready) begin
        beats++;
        m = lfsr_step(m);
      end
      step();
      c++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("beat_count", beats, 8);
    if (!stall) check("done_latency", c, 9);
    check("done_pulse", done, 1);
    check_idle("post_run");
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    level = 5'd0;
    out_ready = 1'b1;
    step();
    step();
    check_idle("reset");
    check("reset_done", done, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle("idle");
      check("idle_done", done, 0);
    end

    run(5'd5, 16'h001F, 1'b0, 1'b0);
    step();
    check("done_once", done, 0);

    run(5'd5, 16'h001F, 1'b1, 1'b0);
    step();
    check("stall_done_once", done, 0);

    // Second run starts in the done cycle; first has a stray start.
    run(5'd5, 16'h001F, 1'b0, 1'b1);
    run(5'd5, 16'h001F, 1'b0, 1'b0);
    step();
    check("b2b_done_once", done, 0);

    run(5'd0, 16'h0000, 1'b0, 1'b0);
    step();
    run(5'd16, 16'hFFFF, 1'b0, 1'b0);
    step();
    run(5'd31, 16'hFFFF, 1'b1, 1'b0);
    step();

    start = 1'b1;
    level = 5'd5;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("pre_rst_idx", idx, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("mid_rst");
    check("mid_rst_done", done, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_no_done", done, 0);
      check("rst_no_valid", out_valid, 0);
    end
    run(5'd5, 16'h001F, 1'b0, 1'b0);
    step();
    check("final_done_low", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/unary_stream_gen.md
Name: unary_stream_gen

Overview:
- Upstream feeder for hv_generator: emits one pair of 16-bit unary (thermometer) bitstreams (a, b) per hypervector dimension.
- a encodes a latched feature level. b encodes a pseudo-random threshold taken from a 16-bit LFSR.
- hv_generator reduces each pair to one HV bit (HVb = 1 iff level > threshold).
- The LFSR is reseeded on every start, so equal levels produce identical, reproducible hypervectors.

Parameters:
- DIM, 1024, number of beats (hypervector dimensions) per run; must be >= 2.
- SEED, 16'hACE1, LFSR load value on start; if SEED==0, the block loads 16'h0001 instead.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a new run; honoured only in IDLE.
- level  in  5  feature level 0..16; sampled on an accepted start; values >16 saturate to 16.
- out_ready  in  1  downstream accepts the current beat.
- out_valid  out  1  a/b/idx hold a valid beat.
- a  out  16  thermometer of the latched level: a[i]=1 iff i < level.
- b  out  16  thermometer of the threshold r=lfsr[3:0]: b[i]=1 iff i < r, so r is 0..15 and b[15] is always 0.
- idx  out  $clog2(DIM)  dimension index of the current beat.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset values: state=IDLE; out_valid=0; busy=0; done=0; a=0; b=0; idx=0; lfsr=SEED (or 1 if SEED==0); level register=0.
- Reset has priority over every other input. Reset mid-run abandons the run with no done pulse.
- FSM, IDLE:
  - out_valid=0, busy=0; a and b are driven as 0.
  - On start=1: latch sat(level); load lfsr with the seed; set idx=0; move to RUN.
  - The first beat is valid in the next cycle, so start-to-valid latency is 1 cycle.
- FSM, RUN:
  - out_valid=1 and busy=1.
  - a and b are registered and are functions of the latched level and the current lfsr.
  - A beat is accepted when out_valid && out_ready.
  - On acceptance with idx < DIM-1: increment idx and advance the lfsr one step. The next beat is presented the following cycle.
  - On acceptance with idx == DIM-1: move to IDLE. out_valid=0 and done=1 in the next cycle; done lasts exactly 1 cycle. idx returns to 0.
  - start is ignored in RUN, including in the final-acceptance cycle.
- Back-pressure:
  - While out_valid=1 and out_ready=0, a, b and idx hold stable and the lfsr does not advance.
  - Throughput is 1 beat per cycle when out_ready is held high.
  - A run with no stalls takes DIM cycles in RUN; done asserts at cycle t+DIM+1 for start at cycle t.
- LFSR:
  - Galois right-shift: next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000).
  - Maximal length; never reaches 0.
  - Advances only on accepted, non-final beats.
- Back-to-back runs: start may be asserted in the cycle done=1, because the state is already IDLE. The new run reloads the seed.
- Level boundaries:
  - level=0 gives a=16'h0000, so every HV bit is 0 downstream.
  - level>=16 gives a=16'hFFFF, so every HV bit is 1 (b[15]=0 always).

Test Plan:
- Reset, then 5 idle cycles -> out_valid=0, busy=0, done=0, a=b=0, idx=0.
- DIM=8, SEED=16'hACE1, level=5, out_ready=1, start pulse:
  - a=16'h001F on all beats.
  - b for beats 0,1,2 = 16'h0001, 16'h0000, 16'h00FF (lfsr ACE1 -> E270 -> 7138).
  - idx counts 0..7.
  - done pulses exactly once, 9 cycles after start.
- Same run with out_ready toggled 1,0,0,1,… -> beats hold stable while stalled; the b sequence is identical to the unstalled run; no beat is dropped or duplicated.
- Two runs with level=5, the second started in the done cycle -> identical a/b/idx sequences; a start pulsed mid-run is ignored (beat count stays 8).
- level=0, level=16 and level=31 runs -> a=16'h0000, 16'hFFFF and 16'hFFFF respectively; b[15]=0 on every beat.
- rst asserted at beat 3 of a run -> next cycle all outputs are at reset values, no done pulse; a new start then reproduces beat 0 with b=16'h0001.
